// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: fetch controller for a 256-word combinational
// instruction ROM. It owns the program counter, registers one instruction
// into an output buffer and hands it to decode over a valid/ready handshake.
// It also handles redirects from execute, stops on a halt word and restarts
// on a start pulse.
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// fetch/stall/redirect performance counters.
module imem_fetch_sequencer #(
    parameter logic [7:0]  RESET_PC  = 8'd0,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_target,
    output logic        busy,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  pc;
    logic        load;
    logic        is_halt_word;

    // Next-state decode, load qualification and ROM address selection
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        imem_addr    = pc;
        is_halt_word = (imem_rd == HALT_WORD);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                load = !instr_valid || instr_ready || redirect_valid;
                if (redirect_valid) begin
                    imem_addr = redirect_target;
                end
                if (start) begin
                    state_next = FETCH;
                end else if (load && is_halt_word) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Program counter and output buffer; a start pulse overrides any load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_pc    <= 8'h0;
            instr_valid <= 1'b0;
        end else if (start) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
        end else if (load) begin
            if (is_halt_word) begin
                pc          <= imem_addr;
                instr_valid <= 1'b0;
            end else begin
                instr       <= imem_rd;
                instr_pc    <= imem_addr;
                instr_valid <= 1'b1;
                pc          <= imem_addr + 8'd1;
            end
        end
    end

    assign busy   = (state == FETCH);
    assign halted = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
    // Saturating performance counters, cleared by reset and by start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt    <= 16'h0;
            stall_cnt    <= 16'h0;
            redirect_cnt <= 16'h0;
        end else if (start) begin
            fetch_cnt    <= 16'h0;
            stall_cnt    <= 16'h0;
            redirect_cnt <= 16'h0;
        end else begin
            if (load && !is_halt_word && (fetch_cnt != 16'hFFFF)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if ((state == FETCH) && instr_valid && !instr_ready && !redirect_valid
                && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if ((state == FETCH) && redirect_valid && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Testbench for imem_fetch_sequencer: a ROM model feeds the DUT, stimulus
// pushes expected deliveries into a scoreboard queue, and a negedge monitor
// pops and compares on every accepted handshake.
module tb_imem_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        busy;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;
`endif

    typedef struct packed {
        logic [31:0] word;
        logic [7:0]  pc;
    } entry_t;

    entry_t expq[$];
    entry_t mon_e;
    int     vectors     = 0;
    int     miscompares = 0;
    int     delivered   = 0;
    int     d0;

    imem_fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .imem_addr       (imem_addr),
        .imem_rd         (imem_rd),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .busy            (busy),
        .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt       (fetch_cnt),
        .stall_cnt       (stall_cnt),
        .redirect_cnt    (redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 14-word test program, zero beyond it, plus a nonzero word at 255
    function automatic logic [31:0] rom(input logic [7:0] a);
        case (a)
            8'd0:    rom = 32'h2001_0003;
            8'd1:    rom = 32'h2002_0009;
            8'd2:    rom = 32'h0022_1020;
            8'd3:    rom = 32'h0022_1822;
            8'd4:    rom = 32'h0041_2024;
            8'd5:    rom = 32'h0041_2825;
            8'd6:    rom = 32'h0022_302A;
            8'd7:    rom = 32'h2001_00CA;
            8'd8:    rom = 32'hAC01_0004;
            8'd9:    rom = 32'h8C03_0004;
            8'd10:   rom = 32'h1022_0002;
            8'd11:   rom = 32'h2004_0001;
            8'd12:   rom = 32'h0800_0000;
            8'd13:   rom = 32'h2005_0007;
            8'd255:  rom = 32'h3C1F_00FF;
            default: rom = 32'h0000_0000;
        endcase
    endfunction

    assign imem_rd = rom(imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic pushPc(input logic [7:0] p);
        expq.push_back({rom(p), p});
    endtask

    // Drive one cycle of inputs; start and redirect are single-cycle pulses
    task automatic applyStimulus(input logic s, input logic r, input logic rv,
                                 input logic [7:0] rt);
        start           = s;
        instr_ready     = r;
        redirect_valid  = rv;
        redirect_target = rt;
        @(posedge clk);
        #1;
        start          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic runToHalt();
        int n;
        n = 0;
        while (!halted && n < 60) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
            n++;
        end
        checkOutput("halt_reached", 32'(halted), 32'd1);
    endtask

    // Monitor: every accepted handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            delivered++;
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_delivery: got pc %0d, expected none", instr_pc);
            end else begin
                mon_e = expq.pop_front();
                checkOutput("deliver_instr", instr, mon_e.word);
                checkOutput("deliver_pc", 32'(instr_pc), 32'(mon_e.pc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        start           = 1'b0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'd0;
        rst_n           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_instr", instr, 32'h0);
        checkOutput("reset_instr_pc", 32'(instr_pc), 32'h0);
        checkOutput("reset_valid", 32'(instr_valid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_halted", 32'(halted), 32'h0);
        checkOutput("reset_addr", 32'(imem_addr), 32'h0);
        rst_n = 1'b1;

        // Full run with instr_ready held high
        for (int p = 0; p < 14; p++) pushPc(8'(p));
        d0 = delivered;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_no_valid_yet", 32'(instr_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("first_valid", 32'(instr_valid), 32'd1);
        checkOutput("first_pc", 32'(instr_pc), 32'd0);
        runToHalt();
        checkOutput("halt_valid", 32'(instr_valid), 32'd0);
        checkOutput("halt_busy", 32'(busy), 32'd0);
        checkOutput("run1_deliveries", 32'(delivered - d0), 32'd14);
        checkOutput("run1_queue_empty", 32'(expq.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("run1_fetch_cnt", 32'(fetch_cnt), 32'd14);
        checkOutput("run1_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // Redirect in HALT is ignored
        redirect_valid  = 1'b1;
        redirect_target = 8'd7;
        #1;
        checkOutput("halt_addr_ignores_redirect", 32'(imem_addr), 32'd14);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd7);
        checkOutput("halt_stays_halted", 32'(halted), 32'd1);
        checkOutput("halt_stays_invalid", 32'(instr_valid), 32'd0);

        // Restart from HALT, then stall on pc2
        pushPc(8'd0);
        pushPc(8'd1);
        pushPc(8'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("restart_first_pc", 32'(instr_pc), 32'd0);
        checkOutput("restart_first_valid", 32'(instr_valid), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
            checkOutput("stall_instr", instr, 32'h0022_1020);
            checkOutput("stall_pc", 32'(instr_pc), 32'd2);
            checkOutput("stall_addr", 32'(imem_addr), 32'd3);
            checkOutput("stall_valid", 32'(instr_valid), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("resume_pc", 32'(instr_pc), 32'd3);

        // Redirect flushes unaccepted pc3
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd7);
        checkOutput("redirect_pc", 32'(instr_pc), 32'd7);
        checkOutput("redirect_instr", instr, 32'h2001_00CA);
        pushPc(8'd7);
        pushPc(8'd8);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("after_redirect_pc", 32'(instr_pc), 32'd8);

        // Redirect to 255 while pc8 is accepted, then wrap to 0
        pushPc(8'd255);
        for (int p = 0; p < 5; p++) pushPc(8'(p));
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd255);
        checkOutput("redirect_255_pc", 32'(instr_pc), 32'd255);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("wrap_pc", 32'(instr_pc), 32'd0);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("midstream_pc", 32'(instr_pc), 32'd5);
        checkOutput("midstream_queue_empty", 32'(expq.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("seg2_fetch_cnt", 32'(fetch_cnt), 32'd13);
        checkOutput("seg2_stall_cnt", 32'(stall_cnt), 32'd3);
        checkOutput("seg2_redirect_cnt", 32'(redirect_cnt), 32'd2);
`endif

        // Asynchronous reset mid-stream
        instr_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(instr_valid), 32'd0);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        checkOutput("async_reset_pc", 32'(instr_pc), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_valid", 32'(instr_valid), 32'd0);
        checkOutput("idle_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("reset_fetch_cnt", 32'(fetch_cnt), 32'd0);
`endif

        // Full run again after reset
        for (int p = 0; p < 14; p++) pushPc(8'(p));
        d0 = delivered;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        runToHalt();
        checkOutput("run3_deliveries", 32'(delivered - d0), 32'd14);
        checkOutput("run3_queue_empty", 32'(expq.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("run3_fetch_cnt", 32'(fetch_cnt), 32'd14);
        checkOutput("run3_redirect_cnt", 32'(redirect_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
